// File: rtl/dma_engine.sv
`default_nettype none
// ============================================================================
//  Module      : dma_engine
//  Description : Word-wise copy engine between host memory and GPU device
//                memory. One outstanding OBI-style transaction at a time,
//                staged through a single-word holding buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module dma_engine #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    // control interface
    input  logic [LEN_WIDTH-1:0]  ctrl_len,
    input  logic [ADDR_WIDTH-1:0] ctrl_src,
    input  logic [ADDR_WIDTH-1:0] ctrl_dst,
    input  logic                  ctrl_dir,
    input  logic                  ctrl_start,
    output logic                  ctrl_done,
    // host memory master port
    output logic                  host_req,
    input  logic                  host_gnt,
    output logic                  host_we,
    output logic [ADDR_WIDTH-1:0] host_addr,
    output logic [31:0]           host_wdata,
    output logic [3:0]            host_be,
    input  logic                  host_rvalid,
    input  logic [31:0]           host_rdata,
    // device memory master port
    output logic                  dev_req,
    input  logic                  dev_gnt,
    output logic                  dev_we,
    output logic [ADDR_WIDTH-1:0] dev_addr,
    output logic [31:0]           dev_wdata,
    output logic [3:0]            dev_be,
    input  logic                  dev_rvalid,
    input  logic [31:0]           dev_rdata
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WR_REQ  = 3'd3,
        S_WR_WAIT = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] C_ADDR_STEP = ADDR_WIDTH'(4);
    localparam logic [LEN_WIDTH-1:0]  C_WORD_ONE  = LEN_WIDTH'(1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic                  dir_q, dir_d;
    logic [LEN_WIDTH-1:0]  words_q, words_d;
    logic [31:0]           buf_q, buf_d;
    logic                  done_q, done_d;

    // Byte-offset bits of the programmed values are deliberately discarded.
    logic w_unused_bits;
    assign w_unused_bits = ^{ctrl_len[1:0], ctrl_src[1:0], ctrl_dst[1:0]};

    // Source is host for dir=0, device for dir=1; destination is the other.
    logic        w_src_gnt, w_src_rvalid, w_dst_gnt, w_dst_rvalid;
    logic [31:0] w_src_rdata;
    assign w_src_gnt    = dir_q ? dev_gnt    : host_gnt;
    assign w_src_rvalid = dir_q ? dev_rvalid : host_rvalid;
    assign w_src_rdata  = dir_q ? dev_rdata  : host_rdata;
    assign w_dst_gnt    = dir_q ? host_gnt    : dev_gnt;
    assign w_dst_rvalid = dir_q ? host_rvalid : dev_rvalid;

    // State and datapath registers; reset aborts any transfer in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            dir_q   <= 1'b0;
            words_q <= '0;
            buf_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            dir_q   <= dir_d;
            words_q <= words_d;
            buf_q   <= buf_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: read one word, write it back, advance, repeat.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        dir_d   = dir_q;
        words_d = words_q;
        buf_d   = buf_q;
        done_d  = done_q;
        case (state_q)
            S_IDLE: begin
                if (ctrl_start) begin
                    src_d   = {ctrl_src[ADDR_WIDTH-1:2], 2'b00};
                    dst_d   = {ctrl_dst[ADDR_WIDTH-1:2], 2'b00};
                    dir_d   = ctrl_dir;
                    words_d = {2'b00, ctrl_len[LEN_WIDTH-1:2]};
                    if (ctrl_len[LEN_WIDTH-1:2] == '0) begin
                        // Nothing to move: complete immediately.
                        done_d = 1'b1;
                    end else begin
                        done_d  = 1'b0;
                        state_d = S_RD_REQ;
                    end
                end
            end
            S_RD_REQ: begin
                if (w_src_gnt) state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (w_src_rvalid) begin
                    buf_d   = w_src_rdata;
                    state_d = S_WR_REQ;
                end
            end
            S_WR_REQ: begin
                if (w_dst_gnt) state_d = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (w_dst_rvalid) begin
                    src_d   = src_q + C_ADDR_STEP;
                    dst_d   = dst_q + C_ADDR_STEP;
                    words_d = words_q - C_WORD_ONE;
                    if (words_q == C_WORD_ONE) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_RD_REQ;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Port drive: only the port in a request phase is active, the other is 0.
    always_comb begin
        host_req   = 1'b0;
        host_we    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
        host_be    = 4'h0;
        dev_req    = 1'b0;
        dev_we     = 1'b0;
        dev_addr   = '0;
        dev_wdata  = '0;
        dev_be     = 4'h0;
        if (state_q == S_RD_REQ) begin
            if (dir_q) begin
                dev_req   = 1'b1;
                dev_addr  = src_q;
                dev_be    = 4'hF;
            end else begin
                host_req  = 1'b1;
                host_addr = src_q;
                host_be   = 4'hF;
            end
        end else if (state_q == S_WR_REQ) begin
            if (dir_q) begin
                host_req   = 1'b1;
                host_we    = 1'b1;
                host_addr  = dst_q;
                host_wdata = buf_q;
                host_be    = 4'hF;
            end else begin
                dev_req    = 1'b1;
                dev_we     = 1'b1;
                dev_addr   = dst_q;
                dev_wdata  = buf_q;
                dev_be     = 4'hF;
            end
        end
    end

    assign ctrl_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_dma_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dma_engine
//  Description : Self-checking bench for dma_engine with OBI memory responders
//                and a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dma_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ctrl_len, ctrl_src, ctrl_dst;
    logic        ctrl_dir, ctrl_start, ctrl_done;
    logic        host_req, host_we, dev_req, dev_we;
    logic [31:0] host_addr, host_wdata, dev_addr, dev_wdata;
    logic [3:0]  host_be, dev_be;
    logic [1:0]  gnt_v    = 2'b00;
    logic [1:0]  rvalid_v = 2'b00;
    logic [31:0] rdata_v [2];

    always #5 clk = ~clk;

    dma_engine #(.ADDR_WIDTH(32), .LEN_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .ctrl_len(ctrl_len), .ctrl_src(ctrl_src), .ctrl_dst(ctrl_dst),
        .ctrl_dir(ctrl_dir), .ctrl_start(ctrl_start), .ctrl_done(ctrl_done),
        .host_req(host_req), .host_gnt(gnt_v[0]), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_be(host_be),
        .host_rvalid(rvalid_v[0]), .host_rdata(rdata_v[0]),
        .dev_req(dev_req), .dev_gnt(gnt_v[1]), .dev_we(dev_we),
        .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_be(dev_be),
        .dev_rvalid(rvalid_v[1]), .dev_rdata(rdata_v[1])
    );

    // Port 0 = host, port 1 = device
    logic [1:0]  p_req, p_we;
    logic [31:0] p_addr [2];
    logic [31:0] p_wd   [2];
    logic [3:0]  p_be   [2];
    assign p_req     = {dev_req, host_req};
    assign p_we      = {dev_we, host_we};
    assign p_addr[0] = host_addr;
    assign p_addr[1] = dev_addr;
    assign p_wd[0]   = host_wdata;
    assign p_wd[1]   = dev_wdata;
    assign p_be[0]   = host_be;
    assign p_be[1]   = dev_be;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- memories ----------------
    logic [31:0] mem0 [logic [31:0]];
    logic [31:0] mem1 [logic [31:0]];

    function automatic logic [31:0] pattern(input int p, input logic [31:0] a);
        return {(p == 1) ? 8'hD0 : 8'hA0, a[23:0]};
    endfunction

    function automatic logic [31:0] mem_rd(input int p, input logic [31:0] a);
        if (p == 0) return mem0.exists(a) ? mem0[a] : pattern(0, a);
        return mem1.exists(a) ? mem1[a] : pattern(1, a);
    endfunction

    // ---------------- OBI responders ----------------
    int stall [2] = '{0, 0};
    initial begin : responder
        int       scnt [2];
        bit       hs   [2];
        bit       hwe  [2];
        logic [31:0] ha [2];
        logic [31:0] hd [2];
        for (int p = 0; p < 2; p++) begin
            scnt[p] = 0; hs[p] = 0; hwe[p] = 0; ha[p] = '0; hd[p] = '0;
            rdata_v[p] = 32'hDEAD_0000;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int p = 0; p < 2; p++) begin
                rvalid_v[p] = hs[p];
                rdata_v[p]  = 32'hDEAD_0000;
                if (hs[p]) begin
                    if (hwe[p]) begin
                        if (p == 0) mem0[ha[p]] = hd[p];
                        else        mem1[ha[p]] = hd[p];
                    end else begin
                        rdata_v[p] = mem_rd(p, ha[p]);
                    end
                end
                if (p_req[p]) begin
                    gnt_v[p] = (scnt[p] >= stall[p]);
                    if (!gnt_v[p]) scnt[p]++;
                end else begin
                    gnt_v[p] = 1'b0;
                    scnt[p]  = 0;
                end
            end
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                hs[p]  = p_req[p] && gnt_v[p];
                hwe[p] = p_we[p];
                ha[p]  = p_addr[p];
                hd[p]  = p_wd[p];
                if (hs[p]) scnt[p] = 0;
            end
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    typedef struct {
        int          p;
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;
    txn_t exp_q [$];

    bit          m_busy = 0, m_pend_wr = 0, m_done = 0, m_started = 0, m_prev_rst = 0;
    int          m_remaining = 0, m_dir = 0;
    bit          prev_stall [2] = '{0, 0};
    bit          prev_we    [2] = '{0, 0};
    logic [31:0] prev_addr  [2];
    logic [31:0] prev_wd    [2];

    initial begin : compare
        txn_t t;
        int   words;
        forever begin
            @(negedge clk);
            if (m_started) begin
                chk(ctrl_done === m_done, "done", 64'(ctrl_done), 64'(m_done));
                chk(!(p_req[0] && p_req[1]), "both_req", 64'(p_req), 64'(0));
                for (int p = 0; p < 2; p++) begin
                    if (!m_busy) chk(p_req[p] === 1'b0, "idle_req", 64'(p_req[p]), 64'(0));
                    if (prev_stall[p] && !m_prev_rst)
                        chk(p_req[p] && p_we[p] == prev_we[p] && p_addr[p] == prev_addr[p] && p_wd[p] == prev_wd[p],
                            "hold_stable", {p_addr[p], p_wd[p]}, {prev_addr[p], prev_wd[p]});
                    if (p_req[p]) begin
                        chk(p_be[p] === 4'hF, "be", 64'(p_be[p]), 64'hF);
                        if (gnt_v[p]) begin
                            if (exp_q.size() == 0) begin
                                chk(1'b0, "unexpected_txn", {p_addr[p], p_wd[p]}, 64'(0));
                            end else begin
                                t = exp_q.pop_front();
                                chk(t.p == p && t.we == p_we[p] && t.addr == p_addr[p] && (!t.we || t.data == p_wd[p]),
                                    t.we ? "write_txn" : "read_txn",
                                    {p_addr[p], p_wd[p]}, {t.addr, t.we ? t.data : p_wd[p]});
                            end
                        end
                    end
                end
            end
            // advance the model to what the next cycle must show
            if (reset) begin
                m_busy = 0; m_pend_wr = 0; m_done = 0; m_remaining = 0;
                exp_q.delete();
            end else if (m_busy) begin
                if (m_pend_wr && rvalid_v[1 - m_dir]) begin
                    m_pend_wr = 0;
                    m_remaining--;
                    if (m_remaining == 0) begin
                        m_busy = 0;
                        m_done = 1;
                    end
                end
                for (int p = 0; p < 2; p++)
                    if (p_req[p] && gnt_v[p] && p_we[p]) m_pend_wr = 1;
            end else if (ctrl_start) begin
                words = int'(ctrl_len >> 2);
                m_done = (words == 0);
                if (words > 0) begin
                    m_busy = 1; m_remaining = words; m_dir = int'(ctrl_dir);
                    for (int i = 0; i < words; i++) begin
                        logic [31:0] sa, da;
                        sa = {ctrl_src[31:2], 2'b00} + 32'(4 * i);
                        da = {ctrl_dst[31:2], 2'b00} + 32'(4 * i);
                        exp_q.push_back('{p: m_dir,     we: 1'b0, addr: sa, data: 32'h0});
                        exp_q.push_back('{p: 1 - m_dir, we: 1'b1, addr: da, data: mem_rd(m_dir, sa)});
                    end
                end
            end
            for (int p = 0; p < 2; p++) begin
                prev_stall[p] = p_req[p] && !gnt_v[p];
                prev_we[p]    = p_we[p];
                prev_addr[p]  = p_addr[p];
                prev_wd[p]    = p_wd[p];
            end
            m_prev_rst = reset;
            m_started  = 1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_xfer(input bit dir, input logic [31:0] len, input logic [31:0] src,
                              input logic [31:0] dst, output int t);
        @(posedge clk); #2;
        ctrl_dir = dir; ctrl_len = len; ctrl_src = src; ctrl_dst = dst;
        ctrl_start = 1'b1;
        t = cyc;
        @(posedge clk); #2;
        ctrl_start = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int tdone);
        tdone = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (ctrl_done === 1'b1) begin
                tdone = cyc;
                break;
            end
        end
        if (tdone < 0) chk(1'b0, "done_timeout", 64'(0), 64'(1));
    endtask

    task automatic chk_all_zero(input string name);
        logic [140:0] v;
        v = {host_req, host_we, host_addr, host_wdata, host_be,
             dev_req, dev_we, dev_addr, dev_wdata, dev_be, ctrl_done};
        chk(v == '0, name, 64'(|v), 64'(0));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- directed tests ----------------
    initial begin : main
        int t, td;
        reset = 1'b1; ctrl_start = 1'b1;
        ctrl_len = 32'd16; ctrl_src = 32'h10; ctrl_dst = 32'h20; ctrl_dir = 1'b0;

        // reset held with a start request present: everything must stay zero
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk_all_zero("reset_outputs");
        end
        @(posedge clk); #2;
        reset = 1'b0; ctrl_start = 1'b0;
        @(negedge clk);
        chk(ctrl_done === 1'b0, "done_after_reset", 64'(ctrl_done), 64'(0));

        // host->dev, 3 words, zero-wait
        start_xfer(1'b0, 32'd12, 32'h100, 32'h40, t);
        wait_done(100, td);
        chk(td == t + 13, "latency_3w", 64'(td - t), 64'(13));
        chk(mem1[32'h40] == 32'hA000_0100, "dev_0x40", 64'(mem1[32'h40]), 64'hA000_0100);
        chk(mem1[32'h48] == 32'hA000_0108, "dev_0x48", 64'(mem1[32'h48]), 64'hA000_0108);

        // dev->host, 2 words, device grant stalled 3 cycles per request
        stall[1] = 3;
        start_xfer(1'b1, 32'd8, 32'h200, 32'h300, t);
        wait_done(100, td);
        chk(td == t + 15, "latency_stall", 64'(td - t), 64'(15));
        chk(mem0[32'h300] == 32'hD000_0200, "host_0x300", 64'(mem0[32'h300]), 64'hD000_0200);
        chk(mem0[32'h304] == 32'hD000_0204, "host_0x304", 64'(mem0[32'h304]), 64'hD000_0204);
        stall[1] = 0;

        // zero-word lengths complete the cycle after start with no requests
        start_xfer(1'b0, 32'd0, 32'h0, 32'h0, t);
        chk(cyc == t + 1 && ctrl_done === 1'b1, "len0_done", 64'(ctrl_done), 64'(1));
        start_xfer(1'b1, 32'd3, 32'h0, 32'h0, t);
        chk(cyc == t + 1 && ctrl_done === 1'b1, "len3_done", 64'(ctrl_done), 64'(1));

        // 4 words; a second start with a new source mid-transfer is ignored
        start_xfer(1'b0, 32'd16, 32'h400, 32'h500, t);
        @(negedge clk);
        chk(ctrl_done === 1'b0, "done_cleared", 64'(ctrl_done), 64'(0));
        @(posedge clk); #2;
        ctrl_src = 32'h800; ctrl_len = 32'd40; ctrl_start = 1'b1;
        @(posedge clk); #2;
        ctrl_start = 1'b0;
        wait_done(100, td);
        chk(td == t + 17, "latency_4w", 64'(td - t), 64'(17));
        chk(mem1[32'h50C] == 32'hA000_040C, "dev_0x50c", 64'(mem1[32'h50C]), 64'hA000_040C);

        // reset during the write-response wait of word 2 of 4
        start_xfer(1'b0, 32'd16, 32'h600, 32'h700, t);
        while (cyc != t + 8) begin
            @(posedge clk); #2;
        end
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        @(negedge clk);
        chk_all_zero("abort_outputs");
        chk(mem1[32'h704] == 32'hA000_0604, "abort_word2", 64'(mem1[32'h704]), 64'hA000_0604);
        chk(!mem1.exists(32'h708), "abort_no_word3", 64'(mem1.exists(32'h708)), 64'(0));
        repeat (3) @(negedge clk);

        // a fresh single-word transfer after the abort
        start_xfer(1'b0, 32'd4, 32'h900, 32'h980, t);
        wait_done(100, td);
        chk(td == t + 5, "latency_1w", 64'(td - t), 64'(5));
        chk(mem1[32'h980] == 32'hA000_0900, "dev_0x980", 64'(mem1[32'h980]), 64'hA000_0900);
        repeat (3) @(negedge clk);
        chk(exp_q.size() == 0, "model_drained", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
